// File: rtl/waypoint_writer.sv
// waypoint_writer: copies a latched set of waypoints into CPU memory while holding the CPU in reset.
// Latency: point 0 is presented the cycle after start; done pulses one cycle after the last accepted write.
// Backpressure: ext_ready low stalls the current write with strobe, address and data held unchanged.
// Optional: define WAYPOINT_CHECKSUM_EN to append a 32-bit wrapping sum word after the last point.
module waypoint_writer #(
  parameter int          NUM_POINTS  = 4,
  parameter int          POINT_W     = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'd4
) (
  input  logic                          adc_sck,
  input  logic                          reset,
  input  logic                          start,
  input  logic [4:0]                    num_pts,
  input  logic [NUM_POINTS*POINT_W-1:0] points,
  input  logic                          ext_ready,
  output logic                          Ext_MemWrite,
  output logic [31:0]                   Ext_DataAdr,
  output logic [31:0]                   Ext_WriteData,
  output logic                          cpu_hold,
  output logic                          busy,
  output logic                          done
);

  localparam logic [4:0] MAX_CNT = 5'(NUM_POINTS);

`ifdef WAYPOINT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, WRITE, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t                          state_q, state_n;
  logic [4:0]                      idx_q, idx_n;
  logic [4:0]                      cnt_q, cnt_n;
  logic [NUM_POINTS*POINT_W-1:0]   pts_q, pts_n;
  logic                            mw_q, mw_n;
  logic [31:0]                     adr_q, adr_n;
  logic [31:0]                     wdat_q, wdat_n;
  logic                            hold_q, hold_n;
  logic                            busy_q, busy_n;
  logic                            done_q, done_n;
  logic [4:0]                      start_cnt;
  logic                            accept;
`ifdef WAYPOINT_CHECKSUM_EN
  logic [31:0]                     sum_q, sum_n;
`endif

  // Selects point i from a packed vector and zero-extends it to a memory word;
  // out-of-range indices read as zero.
  function automatic logic [31:0] point_word(input logic [NUM_POINTS*POINT_W-1:0] vec,
                                             input logic [4:0] i);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NUM_POINTS; k++) begin
      if (i == 5'(k)) r = 32'(vec[k*POINT_W +: POINT_W]);
    end
    return r;
  endfunction

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q;
    pts_n     = pts_q;
    mw_n      = mw_q;
    adr_n     = adr_q;
    wdat_n    = wdat_q;
    hold_n    = hold_q;
    done_n    = 1'b0;
`ifdef WAYPOINT_CHECKSUM_EN
    sum_n     = sum_q;
`endif
    start_cnt = (num_pts > MAX_CNT) ? MAX_CNT : num_pts;
    accept    = mw_q & ext_ready;

    case (state_q)
      IDLE: begin
        mw_n   = 1'b0;
        adr_n  = '0;
        wdat_n = '0;
        if (start) begin
          pts_n  = points;
          cnt_n  = start_cnt;
          idx_n  = '0;
          hold_n = 1'b1;
`ifdef WAYPOINT_CHECKSUM_EN
          sum_n  = '0;
`endif
          if (start_cnt != 5'd0) begin
            state_n = WRITE;
            mw_n    = 1'b1;
            adr_n   = BASE_ADDR;
            wdat_n  = point_word(points, 5'd0);
          end else begin
            // Empty sequence: no memory traffic, release the CPU straight away.
            state_n = DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end
        end
      end

      WRITE: begin
        if (accept) begin
          idx_n = idx_q + 5'd1;
          // Incremental address equals BASE_ADDR + index*ADDR_STRIDE, wrapping at 32 bits.
          adr_n = adr_q + ADDR_STRIDE;
`ifdef WAYPOINT_CHECKSUM_EN
          sum_n = sum_q + point_word(pts_q, idx_q);
`endif
          if (idx_q == cnt_q - 5'd1) begin
`ifdef WAYPOINT_CHECKSUM_EN
            // Checksum word lands right after the last point.
            state_n = CSUM;
            wdat_n  = sum_n;
`else
            state_n = DONE;
            mw_n    = 1'b0;
            adr_n   = '0;
            wdat_n  = '0;
            done_n  = 1'b1;
            hold_n  = 1'b0;
`endif
          end else begin
            wdat_n = point_word(pts_q, idx_q + 5'd1);
          end
        end
      end

`ifdef WAYPOINT_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_n = DONE;
          mw_n    = 1'b0;
          adr_n   = '0;
          wdat_n  = '0;
          done_n  = 1'b1;
          hold_n  = 1'b0;
        end
      end
`endif

      DONE: begin
        state_n = IDLE;
        mw_n    = 1'b0;
        adr_n   = '0;
        wdat_n  = '0;
      end

      default: begin
        state_n = IDLE;
        mw_n    = 1'b0;
        adr_n   = '0;
        wdat_n  = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any sequence and holds the CPU.
  always_ff @(posedge adc_sck) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pts_q   <= '0;
      mw_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WAYPOINT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      pts_q   <= pts_n;
      mw_q    <= mw_n;
      adr_q   <= adr_n;
      wdat_q  <= wdat_n;
      hold_q  <= hold_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef WAYPOINT_CHECKSUM_EN
      sum_q   <= sum_n;
`endif
    end
  end

  assign Ext_MemWrite  = mw_q;
  assign Ext_DataAdr   = adr_q;
  assign Ext_WriteData = wdat_q;
  assign cpu_hold      = hold_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/waypoint_writer.md
WAYPOINT_WRITER -- requirements
Module: waypoint_writer

Interface
REQ-001 Parameter NUM_POINTS, default 4, meaning maximum points per sequence, legal range 1..16.
REQ-002 Parameter POINT_W, default 8, meaning point width in bits, legal range 1..32.
REQ-003 Parameter BASE_ADDR, default 32'h02000000, meaning CPU memory address of point 0.
REQ-004 Parameter ADDR_STRIDE, default 4, meaning address increment between points.
REQ-005 One clock and a synchronous active-high reset: adc_sck  input  1  clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 num_pts  input  5  number of points to write; sampled with start.
REQ-009 points  input  NUM_POINTS*POINT_W  packed points, point i at bits [i*POINT_W +: POINT_W]; sampled with start.
REQ-010 ext_ready  input  1  memory accepts the current write when high.
REQ-011 Ext_MemWrite  output  1  write strobe.
REQ-012 Ext_DataAdr  output  32  write address.
REQ-013 Ext_WriteData  output  32  write data, point zero-extended.
REQ-014 cpu_hold  output  1  reset to CPU; high while the CPU must not run.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  single-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, WRITE, CSUM, DONE; all outputs SHALL be registered.
REQ-018 IDLE: Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, done=0; cpu_hold holds its last value.
REQ-019 IDLE with start=1: latch points, latch count = min(num_pts, NUM_POINTS), clear index and running sum, set cpu_hold=1.
REQ-020 When count > 0, go to WRITE and present point 0 from the next cycle: Ext_MemWrite=1, Ext_DataAdr=BASE_ADDR, Ext_WriteData=point 0.
REQ-021 When count = 0, go directly to DONE and perform no write.
REQ-022 WRITE: a write is accepted on a rising edge where Ext_MemWrite=1 and ext_ready=1; with ext_ready=0, address, data and strobe SHALL hold unchanged.
REQ-023 After each accept, increment the index, add the point to the running sum (32-bit, wrapping), and present the next point at BASE_ADDR + index*ADDR_STRIDE; address arithmetic SHALL be 32-bit wrapping.
REQ-024 On accept of point count-1: go to CSUM if the feature is compiled in, otherwise go to DONE.
REQ-025 DONE: Ext_MemWrite=0, done=1 and cpu_hold=0 for exactly one cycle, then go to IDLE.
REQ-026 start while busy SHALL be ignored, and points/num_pts changes after latching SHALL have no effect.
REQ-027 With ext_ready held high, a sequence of n>0 points (no checksum) SHALL take n cycles of Ext_MemWrite=1, with done one cycle after the last write.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, busy=0, done=0, cpu_hold=1, index=0, sum=0, aborting any sequence in progress.
REQ-029 Power-up state SHALL equal the reset state.

Configuration
REQ-030 Macro WAYPOINT_CHECKSUM_EN defined: CSUM state writes the 32-bit sum of all written points to BASE_ADDR + count*ADDR_STRIDE, under the same ext_ready handshake, then goes to DONE; count=0 still skips directly to DONE.
REQ-031 Macro not defined: the CSUM state and sum logic are absent, and the last point accept goes straight to DONE.

Verification
REQ-032 After reset, start with NUM_POINTS=4, num_pts=2, points={..,8'h1C,8'h05}, ext_ready=1 -> writes 0x05@0x02000000 then 0x1C@0x02000004; done pulses the next cycle and cpu_hold falls with it.
REQ-033 num_pts=9 with NUM_POINTS=4 -> exactly 4 writes, at 0x02000000..0x0200000C.
REQ-034 ext_ready held low for 3 cycles during point 1 -> address 0x02000004 and its data stay stable for 3 cycles with no index advance; the sequence then completes normally.
REQ-035 reset asserted during the write of point 1 -> next cycle Ext_MemWrite=0, busy=0, cpu_hold=1, and no done pulse; a later start restarts from point 0.
REQ-036 WAYPOINT_CHECKSUM_EN defined, points 0xFF,0x01 -> writes 0xFF, 0x01, then 0x00000100@0x02000008, followed by done.
REQ-037 num_pts=0 -> no Ext_MemWrite; done is high one cycle after start; start pulsed during busy in any test is ignored.
